// File: rtl/mem_arbiter.sv
// Three-way memory port arbiter: evict store > dcache load > icache load,
// with icache starvation override and tag-based routing of load answers.
module mem_arbiter #(
  parameter int IDX_W        = 13,
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ev_req,
  input  logic [IDX_W-1:0] i_ev_idx,
  input  logic [63:0]      i_ev_blk,
  output logic             o_ev_ack,
  input  logic             i_dl_req,
  input  logic [IDX_W-1:0] i_dl_idx,
  output logic             o_dl_ack,
  output logic             o_dl_ans,
  output logic [63:0]      o_dl_ans_blk,
  input  logic             i_il_req,
  input  logic [IDX_W-1:0] i_il_idx,
  output logic             o_il_ack,
  output logic             o_il_ans,
  output logic [63:0]      o_il_ans_blk,
  output logic [1:0]       o_mem_qry_cmd,
  output logic [IDX_W-1:0] o_mem_qry_idx,
  output logic [63:0]      o_mem_qry_blk,
  input  logic [TAG_W-1:0] i_mem_ack,
  input  logic [TAG_W-1:0] i_mem_ans_tag,
  input  logic [63:0]      i_mem_ans_blk,
  output logic             o_busy
);

  localparam logic [1:0] MEM_CMD_NONE  = 2'd0;
  localparam logic [1:0] MEM_CMD_LOAD  = 2'd1;
  localparam logic [1:0] MEM_CMD_STORE = 2'd2;
  localparam int N_TAGS = 1 << TAG_W;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {S_IDLE, S_ISSUE} state_e;
  typedef enum logic [1:0] {REQ_NONE, REQ_EV, REQ_DL, REQ_IL} req_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_DL, OWN_IL} owner_e;

  state_e           r_state;
  state_e           w_state_next;
  req_e             r_sel;
  req_e             w_grant;
  logic [1:0]       r_cmd;
  logic [IDX_W-1:0] r_idx;
  logic [63:0]      r_blk;
  logic [CNT_W-1:0] r_starve;
  logic [CNT_W-1:0] w_starve_next;
  logic             r_ev_ack;
  logic             r_dl_ack;
  logic             r_il_ack;
  owner_e           r_owner [N_TAGS];
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_accept;
  logic             w_ack_cycle;
  logic             w_il_force;
  owner_e           w_ans_owner;

  assign w_accept    = (r_state == S_ISSUE) && (i_mem_ack != '0);
  assign w_ack_cycle = r_ev_ack | r_dl_ack | r_il_ack;
  assign w_il_force  = (r_starve == CNT_MAX) && i_il_req;

  // The ack-pulse cycle never grants: the acked requester still shows req high.
  always_comb begin
    w_state_next  = r_state;
    w_grant       = REQ_NONE;
    w_starve_next = r_starve;
    case (r_state)
      S_IDLE: begin
        if (!w_ack_cycle) begin
          if (w_il_force)    w_grant = REQ_IL;
          else if (i_ev_req) w_grant = REQ_EV;
          else if (i_dl_req) w_grant = REQ_DL;
          else if (i_il_req) w_grant = REQ_IL;
        end
        if (w_grant != REQ_NONE) w_state_next = S_ISSUE;
        if (w_grant == REQ_IL) w_starve_next = '0;
        else if (i_il_req && (r_starve != CNT_MAX)) w_starve_next = r_starve + 1'b1;
      end
      S_ISSUE: begin
        if (w_accept) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant_idx = '0;
    case (w_grant)
      REQ_EV:  w_grant_idx = i_ev_idx;
      REQ_DL:  w_grant_idx = i_dl_idx;
      REQ_IL:  w_grant_idx = i_il_idx;
      default: w_grant_idx = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_sel    <= REQ_NONE;
      r_cmd    <= MEM_CMD_NONE;
      r_idx    <= '0;
      r_blk    <= '0;
      r_starve <= '0;
      r_ev_ack <= 1'b0;
      r_dl_ack <= 1'b0;
      r_il_ack <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_starve <= w_starve_next;
      r_ev_ack <= w_accept && (r_sel == REQ_EV);
      r_dl_ack <= w_accept && (r_sel == REQ_DL);
      r_il_ack <= w_accept && (r_sel == REQ_IL);
      if (w_accept) begin
        r_sel <= REQ_NONE;
        r_cmd <= MEM_CMD_NONE;
        r_idx <= '0;
        r_blk <= '0;
      end else if (w_grant != REQ_NONE) begin
        r_sel <= w_grant;
        r_cmd <= (w_grant == REQ_EV) ? MEM_CMD_STORE : MEM_CMD_LOAD;
        r_idx <= w_grant_idx;
        r_blk <= (w_grant == REQ_EV) ? i_ev_blk : 64'd0;
      end
    end
  end

  // A new ownership write takes precedence over the clear from a same-tag answer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_TAGS; i++) r_owner[i] <= OWN_NONE;
    end else begin
      for (int i = 0; i < N_TAGS; i++) begin
        if (w_accept && (r_cmd == MEM_CMD_LOAD) && (i_mem_ack == TAG_W'(i)))
          r_owner[i] <= (r_sel == REQ_DL) ? OWN_DL : OWN_IL;
        else if ((i_mem_ans_tag != '0) && (i_mem_ans_tag == TAG_W'(i)))
          r_owner[i] <= OWN_NONE;
      end
    end
  end

  assign w_ans_owner  = (i_mem_ans_tag != '0) ? r_owner[i_mem_ans_tag] : OWN_NONE;
  assign o_dl_ans     = (w_ans_owner == OWN_DL);
  assign o_il_ans     = (w_ans_owner == OWN_IL);
  assign o_dl_ans_blk = o_dl_ans ? i_mem_ans_blk : 64'd0;
  assign o_il_ans_blk = o_il_ans ? i_mem_ans_blk : 64'd0;

  assign o_ev_ack      = r_ev_ack;
  assign o_dl_ack      = r_dl_ack;
  assign o_il_ack      = r_il_ack;
  assign o_mem_qry_cmd = r_cmd;
  assign o_mem_qry_idx = r_idx;
  assign o_mem_qry_blk = r_blk;
  assign o_busy        = (r_state == S_ISSUE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed sequences, a priority table and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int IDX_W = 13;
  localparam int TAG_W = 4;
  localparam int LIM   = 4;
  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;

  typedef logic [212:0] v_t;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_ev_req = 1'b0;
  logic [IDX_W-1:0] i_ev_idx = '0;
  logic [63:0]      i_ev_blk = '0;
  logic             i_dl_req = 1'b0;
  logic [IDX_W-1:0] i_dl_idx = '0;
  logic             i_il_req = 1'b0;
  logic [IDX_W-1:0] i_il_idx = '0;
  logic [TAG_W-1:0] i_mem_ack = '0;
  logic [TAG_W-1:0] i_mem_ans_tag = '0;
  logic [63:0]      i_mem_ans_blk = '0;
  logic             o_ev_ack, o_dl_ack, o_il_ack, o_dl_ans, o_il_ans, o_busy;
  logic [63:0]      o_dl_ans_blk, o_il_ans_blk, o_mem_qry_blk;
  logic [1:0]       o_mem_qry_cmd;
  logic [IDX_W-1:0] o_mem_qry_idx;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.IDX_W(IDX_W), .TAG_W(TAG_W), .STARVE_LIMIT(LIM)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ev_req(i_ev_req), .i_ev_idx(i_ev_idx), .i_ev_blk(i_ev_blk), .o_ev_ack(o_ev_ack),
    .i_dl_req(i_dl_req), .i_dl_idx(i_dl_idx), .o_dl_ack(o_dl_ack),
    .o_dl_ans(o_dl_ans), .o_dl_ans_blk(o_dl_ans_blk),
    .i_il_req(i_il_req), .i_il_idx(i_il_idx), .o_il_ack(o_il_ack),
    .o_il_ans(o_il_ans), .o_il_ans_blk(o_il_ans_blk),
    .o_mem_qry_cmd(o_mem_qry_cmd), .o_mem_qry_idx(o_mem_qry_idx), .o_mem_qry_blk(o_mem_qry_blk),
    .i_mem_ack(i_mem_ack), .i_mem_ans_tag(i_mem_ans_tag), .i_mem_ans_blk(i_mem_ans_blk),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic ev, dl, il;
    logic [3:0] ack, ans;
    logic [1:0] cmd;
    logic [12:0] idx;
    logic busy;
    logic [2:0] acks;
    logic [1:0] anss;
  } vec_t;
  vec_t tbl [15];

  function automatic v_t outs();
    return {o_mem_qry_cmd, o_mem_qry_idx, o_mem_qry_blk, o_busy, o_ev_ack, o_dl_ack, o_il_ack,
            o_dl_ans, o_dl_ans_blk, o_il_ans, o_il_ans_blk};
  endfunction

  function automatic v_t mk(logic [1:0] cmd, logic [12:0] idx, logic [63:0] blk, logic busy,
                            logic [2:0] acks, logic dla, logic [63:0] dlb, logic ila, logic [63:0] ilb);
    return {cmd, idx, blk, busy, acks, dla, dlb, ila, ilb};
  endfunction

  task automatic chk(input string name, input v_t got, input v_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_row(input int i, input logic ev, input logic dl, input logic il,
                         input logic [3:0] ack, input logic [3:0] ans, input logic [1:0] cmd,
                         input logic [12:0] idx, input logic busy, input logic [2:0] acks,
                         input logic [1:0] anss);
    tbl[i].ev = ev; tbl[i].dl = dl; tbl[i].il = il; tbl[i].ack = ack; tbl[i].ans = ans;
    tbl[i].cmd = cmd; tbl[i].idx = idx; tbl[i].busy = busy; tbl[i].acks = acks; tbl[i].anss = anss;
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    i_ev_req = 1'b0; i_dl_req = 1'b0; i_il_req = 1'b0;
    i_mem_ack = '0; i_mem_ans_tag = '0; i_mem_ans_blk = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  // who: 2 = dcache load, 3 = icache load
  task automatic do_load(input int who, input logic [12:0] idx, input logic [3:0] tag);
    int n;
    @(posedge i_clk); #1;
    if (who == 2) begin i_dl_req = 1'b1; i_dl_idx = idx; end
    else begin i_il_req = 1'b1; i_il_idx = idx; end
    n = 0;
    do begin @(posedge i_clk); #1; n++; end while (!o_busy && n < 10);
    chk("load_issue", v_t'({o_busy, o_mem_qry_cmd, o_mem_qry_idx}), v_t'({1'b1, C_LOAD, idx}));
    i_mem_ack = tag;
    @(posedge i_clk); #1;
    i_mem_ack = '0;
    chk("load_ack_pulse", v_t'({o_dl_ack, o_il_ack}), v_t'({who == 2, who == 3}));
    @(posedge i_clk); #1;
    i_dl_req = 1'b0; i_il_req = 1'b0;
  endtask

  // Reference model: one pending transaction, an ack owed to a requester,
  // a starvation count and a tag->owner array (0 none, 2 dl, 3 il).
  task automatic run_random(input int cycles);
    bit          rq [4];
    logic [12:0] rix [4];
    int          m_own [16];
    int          m_pend, m_ackw, ackw_prev, m_starve, g, own;
    logic [12:0] m_idx;
    logic [63:0] m_blk;
    logic [1:0]  e_cmd;
    bit          was_idle;
    for (int i = 0; i < 16; i++) m_own[i] = 0;
    for (int r = 0; r < 4; r++) begin rq[r] = 1'b0; rix[r] = '0; end
    m_pend = 0; m_ackw = 0; ackw_prev = 0; m_starve = 0; m_idx = '0; m_blk = '0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(posedge i_clk); #1;
      for (int r = 1; r < 4; r++) begin
        if (ackw_prev == r) rq[r] = 1'b0;
        else if (!rq[r] && $urandom_range(0, 2) == 0) begin
          rq[r] = 1'b1;
          rix[r] = 13'($urandom);
          if (r == 1) i_ev_blk = {$urandom, $urandom};
        end
      end
      i_ev_req = rq[1]; i_ev_idx = rix[1];
      i_dl_req = rq[2]; i_dl_idx = rix[2];
      i_il_req = rq[3]; i_il_idx = rix[3];
      i_mem_ack = (m_pend != 0 && $urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      i_mem_ans_tag = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      i_mem_ans_blk = {$urandom, $urandom};
      e_cmd = (m_pend == 0) ? C_NONE : ((m_pend == 1) ? C_STORE : C_LOAD);
      own = (i_mem_ans_tag != 0) ? m_own[i_mem_ans_tag] : 0;
      @(negedge i_clk);
      chk("random_cycle", outs(),
          mk(e_cmd, (m_pend != 0) ? m_idx : 13'd0, (m_pend == 1) ? m_blk : 64'd0, m_pend != 0,
             {m_ackw == 1, m_ackw == 2, m_ackw == 3},
             own == 2, (own == 2) ? i_mem_ans_blk : 64'd0,
             own == 3, (own == 3) ? i_mem_ans_blk : 64'd0));
      ackw_prev = m_ackw;
      m_ackw = 0;
      was_idle = (m_pend == 0);
      if (i_mem_ans_tag != 0) m_own[i_mem_ans_tag] = 0;
      if (!was_idle) begin
        if (i_mem_ack != 0) begin
          if (m_pend != 1) m_own[i_mem_ack] = m_pend;
          m_ackw = m_pend;
          m_pend = 0;
        end
      end else begin
        g = 0;
        if (ackw_prev == 0) begin
          if (m_starve == LIM && rq[3]) g = 3;
          else if (rq[1]) g = 1;
          else if (rq[2]) g = 2;
          else if (rq[3]) g = 3;
        end
        if (g == 3) m_starve = 0;
        else if (rq[3] && m_starve < LIM) m_starve++;
        if (g != 0) begin
          m_pend = g;
          m_idx = rix[g];
          m_blk = i_ev_blk;
        end
      end
    end
  endtask

  initial begin
    int nq, il_at, busy_cnt;
    logic [1:0] first_cmd;
    logic [63:0] ablk;

    // Priority table: ev idx 5 / dl idx 2 / il idx 7, acked with tags 2, 3, 4
    set_row(0,  1'b1, 1'b1, 1'b1, 4'd0, 4'd0, C_NONE,  13'd0, 1'b0, 3'b000, 2'b00);
    set_row(1,  1'b1, 1'b1, 1'b1, 4'd0, 4'd0, C_STORE, 13'd5, 1'b1, 3'b000, 2'b00);
    set_row(2,  1'b1, 1'b1, 1'b1, 4'd2, 4'd0, C_STORE, 13'd5, 1'b1, 3'b000, 2'b00);
    set_row(3,  1'b1, 1'b1, 1'b1, 4'd0, 4'd0, C_NONE,  13'd0, 1'b0, 3'b100, 2'b00);
    set_row(4,  1'b0, 1'b1, 1'b1, 4'd0, 4'd0, C_NONE,  13'd0, 1'b0, 3'b000, 2'b00);
    set_row(5,  1'b0, 1'b1, 1'b1, 4'd0, 4'd0, C_LOAD,  13'd2, 1'b1, 3'b000, 2'b00);
    set_row(6,  1'b0, 1'b1, 1'b1, 4'd3, 4'd0, C_LOAD,  13'd2, 1'b1, 3'b000, 2'b00);
    set_row(7,  1'b0, 1'b1, 1'b1, 4'd0, 4'd0, C_NONE,  13'd0, 1'b0, 3'b010, 2'b00);
    set_row(8,  1'b0, 1'b0, 1'b1, 4'd0, 4'd0, C_NONE,  13'd0, 1'b0, 3'b000, 2'b00);
    set_row(9,  1'b0, 1'b0, 1'b1, 4'd4, 4'd0, C_LOAD,  13'd7, 1'b1, 3'b000, 2'b00);
    set_row(10, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, C_NONE,  13'd0, 1'b0, 3'b001, 2'b00);
    set_row(11, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, C_NONE,  13'd0, 1'b0, 3'b000, 2'b00);
    set_row(12, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, C_NONE,  13'd0, 1'b0, 3'b000, 2'b10);
    set_row(13, 1'b0, 1'b0, 1'b0, 4'd0, 4'd4, C_NONE,  13'd0, 1'b0, 3'b000, 2'b01);
    set_row(14, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, C_NONE,  13'd0, 1'b0, 3'b000, 2'b00);

    // Reset state
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("reset_idle_outputs", outs(), v_t'(0));
      @(posedge i_clk); #1;
    end

    // Single dcache load, held query, ack pulse, answer
    i_dl_req = 1'b1; i_dl_idx = 13'd2;
    @(negedge i_clk);
    chk("dl_request_cycle", v_t'({o_mem_qry_cmd, o_busy}), v_t'({C_NONE, 1'b0}));
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("dl_query_n_plus_1", v_t'({o_mem_qry_cmd, o_mem_qry_idx, o_mem_qry_blk, o_busy}),
        v_t'({C_LOAD, 13'd2, 64'd0, 1'b1}));
    for (int i = 0; i < 2; i++) begin
      @(posedge i_clk); #1;
      @(negedge i_clk);
      chk("dl_query_held", v_t'({o_mem_qry_cmd, o_mem_qry_idx, o_dl_ack}), v_t'({C_LOAD, 13'd2, 1'b0}));
    end
    @(posedge i_clk); #1; i_mem_ack = 4'd1;
    @(negedge i_clk);
    chk("dl_ack_not_yet", v_t'({o_dl_ack, o_mem_qry_cmd}), v_t'({1'b0, C_LOAD}));
    @(posedge i_clk); #1; i_mem_ack = 4'd0;
    @(negedge i_clk);
    chk("dl_ack_pulse", v_t'({o_dl_ack, o_ev_ack, o_il_ack, o_mem_qry_cmd, o_busy}),
        v_t'({1'b1, 1'b0, 1'b0, C_NONE, 1'b0}));
    @(posedge i_clk); #1; i_dl_req = 1'b0;
    @(negedge i_clk);
    chk("dl_ack_one_cycle", v_t'(o_dl_ack), v_t'(0));
    @(posedge i_clk); #1; i_mem_ans_tag = 4'd1; i_mem_ans_blk = 64'hdeadbeefcc00ffee;
    @(negedge i_clk);
    chk("dl_answer", v_t'({o_dl_ans, o_dl_ans_blk, o_il_ans, o_il_ans_blk}),
        v_t'({1'b1, 64'hdeadbeefcc00ffee, 1'b0, 64'd0}));
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("dl_answer_repeat_ignored", v_t'({o_dl_ans, o_dl_ans_blk, o_il_ans}), v_t'(0));
    @(posedge i_clk); #1; i_mem_ans_tag = '0;

    // Priority table
    do_reset();
    i_ev_idx = 13'd5; i_ev_blk = 64'h1234; i_dl_idx = 13'd2; i_il_idx = 13'd7;
    for (int i = 0; i < 15; i++) begin
      @(posedge i_clk); #1;
      i_ev_req = tbl[i].ev; i_dl_req = tbl[i].dl; i_il_req = tbl[i].il;
      i_mem_ack = tbl[i].ack; i_mem_ans_tag = tbl[i].ans;
      ablk = 64'hA5A5_0000_0000_0000 | 64'(tbl[i].ans);
      i_mem_ans_blk = ablk;
      @(negedge i_clk);
      chk("priority_table", outs(),
          mk(tbl[i].cmd, tbl[i].idx, (tbl[i].cmd == C_STORE) ? 64'h1234 : 64'd0, tbl[i].busy, tbl[i].acks,
             tbl[i].anss[1], tbl[i].anss[1] ? ablk : 64'd0, tbl[i].anss[0], tbl[i].anss[0] ? ablk : 64'd0));
    end

    // Starvation: ev and dl always requesting, each query acked in its second cycle
    do_reset();
    i_ev_req = 1'b1; i_ev_idx = 13'd1; i_ev_blk = 64'h77;
    i_dl_req = 1'b1; i_dl_idx = 13'd2;
    i_il_req = 1'b1; i_il_idx = 13'd3;
    nq = 0; il_at = 0; busy_cnt = 0; first_cmd = C_NONE;
    for (int c = 0; c < 60 && il_at == 0; c++) begin
      @(posedge i_clk); #1;
      if (o_busy) begin
        busy_cnt++;
        if (busy_cnt == 1) begin
          nq++;
          if (nq == 1) first_cmd = o_mem_qry_cmd;
          if (o_mem_qry_idx == 13'd3) il_at = nq;
        end
        i_mem_ack = (busy_cnt == 2) ? 4'd1 : 4'd0;
      end else begin
        busy_cnt = 0;
        i_mem_ack = '0;
      end
    end
    chk("starve_first_grant_ev", v_t'(first_cmd), v_t'(C_STORE));
    chk("starve_il_grant_slot", v_t'(il_at), v_t'(3));

    // Out-of-order answers for two tags
    do_reset();
    do_load(3, 13'd9, 4'd3);
    do_load(2, 13'd4, 4'd5);
    @(posedge i_clk); #1; i_mem_ans_tag = 4'd5; i_mem_ans_blk = 64'h1111_2222_3333_4444;
    @(negedge i_clk);
    chk("ans_tag5_to_dl", v_t'({o_dl_ans, o_dl_ans_blk, o_il_ans, o_il_ans_blk}),
        v_t'({1'b1, 64'h1111_2222_3333_4444, 1'b0, 64'd0}));
    @(posedge i_clk); #1; i_mem_ans_tag = 4'd3; i_mem_ans_blk = 64'h5555_6666_7777_8888;
    @(negedge i_clk);
    chk("ans_tag3_to_il", v_t'({o_dl_ans, o_dl_ans_blk, o_il_ans, o_il_ans_blk}),
        v_t'({1'b0, 64'd0, 1'b1, 64'h5555_6666_7777_8888}));
    @(posedge i_clk); #1; i_mem_ans_tag = 4'd3; i_mem_ans_blk = 64'h9999;
    @(negedge i_clk);
    chk("ans_tag3_again_ignored", v_t'({o_dl_ans, o_dl_ans_blk, o_il_ans, o_il_ans_blk}), v_t'(0));
    @(posedge i_clk); #1; i_mem_ans_tag = '0;

    // Reset in the middle of an issue
    do_reset();
    do_load(2, 13'd6, 4'd6);
    @(posedge i_clk); #1; i_dl_req = 1'b1; i_dl_idx = 13'd8;
    @(posedge i_clk); #1;
    chk("pre_reset_issue", v_t'({o_busy, o_mem_qry_cmd, o_mem_qry_idx}), v_t'({1'b1, C_LOAD, 13'd8}));
    #2 i_rst_n = 1'b0;
    #1 chk("async_reset_clears", outs(), v_t'(0));
    i_dl_req = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1; i_rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      chk("no_ack_after_reset", outs(), v_t'(0));
      @(posedge i_clk); #1;
    end
    i_mem_ans_tag = 4'd6; i_mem_ans_blk = 64'hABCD;
    @(negedge i_clk);
    chk("lost_tag_answer_ignored", outs(), v_t'(0));
    @(posedge i_clk); #1; i_mem_ans_tag = '0;

    // Randomized traffic against the reference model
    do_reset();
    run_random(1500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port among three requesters.
- Requesters, in priority order: the data-cache evict writeback (store), the data-cache miss fill (load) and the instruction-cache miss fill (load).
- Holds the granted request on the memory port until memory accepts it with a non-zero tag.
- Records which requester owns each load tag and routes the tagged answer back to that requester.
- Sits between the ds/icache blocks and the memory interface.

Parameters:
- IDX_W, 13, width of the memory block index (8-byte blocks).
- TAG_W, 4, width of memory transaction tags; tag 0 means "no tag".
- STARVE_LIMIT, 4, number of consecutive denied cycles after which the instruction cache wins the next grant.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- ev_req  in  1  evict writeback request; held high until ev_ack.
- ev_idx  in  IDX_W  evict block index.
- ev_blk  in  64  evict block data.
- ev_ack  out  1  one-cycle pulse: evict store accepted by memory.
- dl_req  in  1  data-cache load request; held until dl_ack.
- dl_idx  in  IDX_W  data-cache load index.
- dl_ack  out  1  one-cycle pulse: data-cache load accepted.
- dl_ans  out  1  one-cycle pulse: data-cache load data valid.
- dl_ans_blk  out  64  data-cache load data.
- il_req  in  1  instruction-cache load request; held until il_ack.
- il_idx  in  IDX_W  instruction-cache load index.
- il_ack  out  1  one-cycle pulse: instruction-cache load accepted.
- il_ans  out  1  one-cycle pulse: instruction-cache load data valid.
- il_ans_blk  out  64  instruction-cache load data.
- mem_qry_cmd  out  2  MEM_CMD_NONE / MEM_CMD_LOAD / MEM_CMD_STORE.
- mem_qry_idx  out  IDX_W  memory index.
- mem_qry_blk  out  64  store data; 0 for loads.
- mem_ack  in  TAG_W  non-zero tag = request accepted this cycle.
- mem_ans_tag  in  TAG_W  non-zero = answer for this tag.
- mem_ans_blk  in  64  answer data.
- busy  out  1  high while in ISSUE.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE; starvation counter cleared; all owner-table entries set to NONE.
  - All outputs 0; mem_qry_cmd = MEM_CMD_NONE.
- State IDLE:
  - Default grant priority is ev > dl > il.
  - When the starvation counter equals STARVE_LIMIT and il_req is high, il wins regardless of the other requests.
  - On any grant: latch cmd/idx/blk into the issue register and move to ISSUE.
  - mem_qry_* shows the latched request from the next cycle, so latency is request cycle N to memory query at N+1.
- State ISSUE:
  - Drive the latched request unchanged; ignore all requester inputs.
  - When mem_ack != 0:
    - At the next posedge, pulse the owner's *_ack for one cycle.
    - Write owner[mem_ack] = DL or IL (loads only; stores record nothing).
    - Clear the issue register (mem_qry_cmd = NONE from that edge) and return to IDLE.
- Re-grant timing:
  - Earliest new grant is in the IDLE cycle after the ack pulse.
  - A requester must drop or change req in the cycle its ack is seen.
- Starvation counter (saturating at STARVE_LIMIT):
  - Increments each IDLE cycle in which il_req is high and il is not granted.
  - Clears when il is granted.
- Answer routing (combinational, in any state):
  - When mem_ans_tag != 0 and owner[mem_ans_tag] is DL: dl_ans = 1 and dl_ans_blk = mem_ans_blk in the same cycle. IL likewise drives il_ans / il_ans_blk.
  - The owner entry is cleared at the following posedge.
  - An answer whose owner is NONE is ignored; both *_ans stay 0.
  - *_ans_blk is 0 whenever the corresponding *_ans is 0.
- Simultaneous events:
  - An answer and a mem_ack for different tags in the same cycle are both processed.
  - If mem_ack equals mem_ans_tag in the same cycle, the answer is routed by the old owner and the new owner is written; the write wins in the table.
- Reset mid-ISSUE: the request is dropped, no ack is produced and the owner table is cleared; in-flight answers are then ignored.

Test Plan:
- Reset low for 2 cycles, then high, with no requests → all outputs 0 and mem_qry_cmd = NONE for 3 cycles.
- dl_req = 1, dl_idx = 2 → at N+1: mem_qry_cmd = LOAD, mem_qry_idx = 2; hold mem_ack = 0 for 2 cycles → query held and dl_ack = 0; mem_ack = 1 → dl_ack pulses at the next edge; later mem_ans_tag = 1 with blk 64'hdeadbeefcc00ffee → dl_ans = 1 and dl_ans_blk = 64'hdeadbeefcc00ffee that cycle.
- ev_req (idx 5, blk 64'h1234), dl_req and il_req all asserted together → STORE to idx 5 with blk 64'h1234 issued first, then dl, then il; ev_ack produces no owner-table entry.
- dl_req and ev_req kept asserted continuously with il_req high, every mem_ack = 1 after one cycle → il is granted once the counter reaches 4, i.e. by its 5th denial opportunity.
- il load accepted with tag 3 and dl load accepted with tag 5; answers return tag 5 then tag 3 → dl_ans fires first, then il_ans, each with its own data; a later answer with tag 3 is ignored.
- Reset driven low during ISSUE with mem_qry_cmd = LOAD → outputs clear immediately without waiting for a clock edge; no ack follows; a following mem_ans_tag for the lost tag produces no *_ans.
